// File: rtl/fifo_write_arbiter.sv
// Round-robin burst write arbiter sharing one FIFO write port among NUM_REQ requesters.
// States: IDLE = arbitration bubble, no writes | GRANT = owner writes up to MAX_BURST words.
module fifo_write_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    input  logic                          full_flag,
    output logic                          fifo_write,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic                          busy,
    output logic [2:0]                    owner_id,
    output logic [15:0]                   words_written
);

    localparam int IDXW = $clog2(NUM_REQ);
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDXW-1:0] owner_q, owner_d;
    logic [7:0]      burst_q, burst_d;
    logic [15:0]     ww_q, ww_d;

    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
    logic [IDXW-1:0]       cand;
    logic [IDXW-1:0]       sel_idx;
    logic                  sel_valid;
    logic [IDXW-1:0]       owner_nxt;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Scan from the highest offset down so the nearest set bit after rr_ptr wins.
    always_comb begin
        cand      = '0;
        sel_idx   = '0;
        sel_valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDXW'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (req[cand]) begin
                sel_valid = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign owner_nxt = (owner_q == IDXW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        burst_d    = burst_q;
        ww_d       = ww_q;
        fifo_write = 1'b0;
        fifo_data  = '0;
        ack        = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    state_d = ST_GRANT;
                    owner_d = sel_idx;
                    burst_d = '0;
                end
            end
            ST_GRANT: begin
                fifo_data = data_arr[owner_q];
                if (!req[owner_q]) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = owner_nxt;
                end else if (!full_flag) begin
                    fifo_write   = 1'b1;
                    ack[owner_q] = 1'b1;
                    burst_d      = burst_q + 8'd1;
                    ww_d         = ww_q + 16'd1;
                    if (burst_q == BURST_LAST) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = owner_nxt;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            burst_q  <= '0;
            ww_q     <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            burst_q  <= burst_d;
            ww_q     <= ww_d;
        end
    end

    assign busy          = (state_q == ST_GRANT);
    assign owner_id      = 3'(owner_q);
    assign words_written = ww_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: vector table for steady-state cases,
// hand sequences for counting data and mid-burst reset.
module tb_fifo_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = '0;
    logic [63:0] req_data = '0;
    logic        full_flag = 1'b0;
    logic [3:0]  ack;
    logic        fifo_write;
    logic [15:0] fifo_data;
    logic        busy;
    logic [2:0]  owner_id;
    logic [15:0] words_written;

    localparam logic [63:0] FIXED_DATA = {16'h1300, 16'h1200, 16'h1100, 16'h1000};

    fifo_write_arbiter #(.DATA_WIDTH(16), .NUM_REQ(4), .MAX_BURST(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_data      (req_data),
        .ack           (ack),
        .full_flag     (full_flag),
        .fifo_write    (fifo_write),
        .fifo_data     (fifo_data),
        .busy          (busy),
        .owner_id      (owner_id),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        rst_n;
        logic [3:0]  req;
        logic        full;
        logic        wr;
        logic [3:0]  ack;
        logic        busy;
        logic [2:0]  own;
        logic [15:0] data;
        logic [15:0] ww;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] rq, input logic f,
                       input logic wr, input logic [3:0] ak, input logic bz,
                       input logic [2:0] ow, input logic [15:0] dt, input logic [15:0] w);
        vec_t v;
        v.rst_n = r;  v.req = rq; v.full = f; v.wr = wr; v.ack = ak;
        v.busy  = bz; v.own = ow; v.data = dt; v.ww = w;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // owner_id and fifo_data are only meaningful while busy; in reset fifo_data must be 0.
    task automatic chk_all(input string tag, input logic in_rst, input logic wr,
                           input logic [3:0] ak, input logic bz, input logic [2:0] ow,
                           input logic [15:0] dt, input logic [15:0] w);
        chk({tag, ".fifo_write"}, 32'(fifo_write), 32'(wr));
        chk({tag, ".ack"}, 32'(ack), 32'(ak));
        chk({tag, ".busy"}, 32'(busy), 32'(bz));
        chk({tag, ".words_written"}, 32'(words_written), 32'(w));
        if (bz) chk({tag, ".owner_id"}, 32'(owner_id), 32'(ow));
        if (bz || in_rst) chk({tag, ".fifo_data"}, 32'(fifo_data), 32'(dt));
    endtask

    task automatic step(input logic r, input logic [3:0] rq);
        @(negedge clk);
        rst = r;
        req = rq;
        #2;
    endtask

    initial begin
        logic [15:0] ww;
        logic [15:0] word;
        logic        exp_wr;

        // Idle after reset.
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 16'h0, 16'd0);
        for (int i = 0; i < 10; i++) add(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 16'h0, 16'd0);

        // All four requesting: bursts of 4 in order 0..3, bubble between grants.
        ww = 16'd0;
        for (int o = 0; o < 4; o++) begin
            add(1, 4'b1111, 0, 0, 4'b0000, 0, 0, 16'h0, ww);
            for (int k = 0; k < 4; k++) begin
                add(1, 4'b1111, 0, 1, 4'(1 << o), 1, 3'(o), 16'h1000 + 16'(o * 256), ww);
                ww = ww + 16'd1;
            end
        end
        add(1, 4'b1111, 0, 0, 4'b0000, 0, 0, 16'h0, 16'd16);

        // Owner 2 stalled by full_flag for 3 cycles after its 2nd word, then full+release together.
        add(0, 4'b0100, 0, 0, 4'b0000, 0, 0, 16'h0, 16'd0);
        add(1, 4'b0100, 0, 0, 4'b0000, 0, 0, 16'h0, 16'd0);
        add(1, 4'b0100, 0, 1, 4'b0100, 1, 2, 16'h1200, 16'd0);
        add(1, 4'b0100, 0, 1, 4'b0100, 1, 2, 16'h1200, 16'd1);
        for (int i = 0; i < 3; i++) add(1, 4'b0100, 1, 0, 4'b0000, 1, 2, 16'h1200, 16'd2);
        add(1, 4'b0100, 0, 1, 4'b0100, 1, 2, 16'h1200, 16'd2);
        add(1, 4'b0100, 0, 1, 4'b0100, 1, 2, 16'h1200, 16'd3);
        add(1, 4'b0100, 0, 0, 4'b0000, 0, 0, 16'h0, 16'd4);
        add(1, 4'b0000, 1, 0, 4'b0000, 1, 2, 16'h1200, 16'd4);
        add(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 16'h0, 16'd4);

        // Owner 1 drops req after 2 words; next grant goes to 2, not 0.
        add(0, 4'b0010, 0, 0, 4'b0000, 0, 0, 16'h0, 16'd0);
        add(1, 4'b0010, 0, 0, 4'b0000, 0, 0, 16'h0, 16'd0);
        add(1, 4'b0111, 0, 1, 4'b0010, 1, 1, 16'h1100, 16'd0);
        add(1, 4'b0111, 0, 1, 4'b0010, 1, 1, 16'h1100, 16'd1);
        add(1, 4'b0101, 0, 0, 4'b0000, 1, 1, 16'h1100, 16'd2);
        add(1, 4'b0101, 0, 0, 4'b0000, 0, 0, 16'h0, 16'd2);
        add(1, 4'b0101, 0, 1, 4'b0100, 1, 2, 16'h1200, 16'd2);

        req_data = FIXED_DATA;
        foreach (vecs[i]) begin
            @(negedge clk);
            rst       = vecs[i].rst_n;
            req       = vecs[i].req;
            full_flag = vecs[i].full;
            #2;
            chk_all($sformatf("vec%0d", i), !vecs[i].rst_n, vecs[i].wr, vecs[i].ack,
                    vecs[i].busy, vecs[i].own, vecs[i].data, vecs[i].ww);
        end
        full_flag = 1'b0;

        // Single requester with counting data: 1..4, bubble, 5..8.
        step(0, 4'b0000);
        step(1, 4'b0000);
        word = 16'd1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            req_data[15:0] = word;
            req = 4'b0001;
            #2;
            exp_wr = (c != 0) && (c != 5);
            if (exp_wr) chk_all($sformatf("count%0d", c), 0, 1, 4'b0001, 1, 0, word, word - 16'd1);
            else        chk_all($sformatf("count%0d", c), 0, 0, 4'b0000, 0, 0, 16'h0, word - 16'd1);
            if (exp_wr) word = word + 16'd1;
        end
        req_data = FIXED_DATA;
        step(1, 4'b0011);
        chk_all("count_idle", 0, 0, 4'b0000, 0, 0, 16'h0, 16'd8);
        step(1, 4'b0011);
        chk_all("count_rr", 0, 1, 4'b0010, 1, 1, 16'h1100, 16'd8);

        // Mid-burst reset: move rr_ptr to 3 first, then reset during owner 3's 3rd word.
        step(0, 4'b0000);
        step(1, 4'b0100);
        chk_all("rst_s1", 0, 0, 4'b0000, 0, 0, 16'h0, 16'd0);
        step(1, 4'b0100);
        chk_all("rst_s2", 0, 1, 4'b0100, 1, 2, 16'h1200, 16'd0);
        step(1, 4'b1000);
        chk_all("rst_s3", 0, 0, 4'b0000, 1, 2, 16'h1200, 16'd1);
        step(1, 4'b1000);
        chk_all("rst_s4", 0, 0, 4'b0000, 0, 0, 16'h0, 16'd1);
        step(1, 4'b1000);
        chk_all("rst_s5", 0, 1, 4'b1000, 1, 3, 16'h1300, 16'd1);
        step(1, 4'b1000);
        chk_all("rst_s6", 0, 1, 4'b1000, 1, 3, 16'h1300, 16'd2);
        step(0, 4'b1010);
        chk_all("rst_s7", 1, 0, 4'b0000, 0, 0, 16'h0, 16'd0);
        step(1, 4'b1010);
        chk_all("rst_s8", 0, 0, 4'b0000, 0, 0, 16'h0, 16'd0);
        step(1, 4'b1010);
        chk_all("rst_s9", 0, 1, 4'b0010, 1, 1, 16'h1100, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
